cpu_control_unit: RTL and testbench

Multi-cycle control and execute stage of the 16-bit CPU, sitting directly upstream of the 16×16 register file. It accepts one instruction at a time over a valid/ready handshake and decodes it. It drives the register file's two combinational read ports, computes the result (ADD/SUB/ADDI/MUL/LOAD/CLR), and issues a single-cycle write (`regWrite`, `write_reg_addr`, `write_data`) back into the register file. Only one instruction is in flight, so there are no hazards to manage.

---
 rtl/cpu_pkg.sv | 40 ++++
 rtl/cpu_mul_iter.sv | 53 +++++
 rtl/cpu_control_unit.sv | 138 +++++++++++++
 tb/tb_cpu_control_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU control/execute slice: widths,
// instruction field positions, opcodes and the control FSM state type.
package cpu_pkg;

  localparam int CPU_DATA_W = 16;
  localparam int CPU_ADDR_W = 4;
  localparam int INSTR_W    = 16;

  localparam int OP_LSB   = 12;
  localparam int RD_LSB   = 8;
  localparam int RS1_LSB  = 4;
  localparam int RS2_LSB  = 0;
  localparam int IMM4_LSB = 0;
  localparam int IMM8_LSB = 0;
  localparam int FIELD_W  = 4;
  localparam int IMM8_W   = 8;

  typedef logic [FIELD_W-1:0] opcode_t;

  localparam opcode_t OP_NOP  = 4'h0;
  localparam opcode_t OP_LOAD = 4'h1;
  localparam opcode_t OP_ADD  = 4'h2;
  localparam opcode_t OP_SUB  = 4'h3;
  localparam opcode_t OP_ADDI = 4'h4;
  localparam opcode_t OP_MUL  = 4'h5;
  localparam opcode_t OP_CLR  = 4'h6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_MUL,
    S_WB
  } state_t;

  function automatic logic is_legal(input opcode_t op);
    return op <= OP_CLR;
  endfunction

endpackage

// File: rtl/cpu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle for W cycles,
// keeping only the low W bits of the product.
module cpu_mul_iter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] product
);

  localparam int CNT_W = $clog2(W);

  logic             running;
  logic [CNT_W-1:0] count;
  logic [W-1:0]     acc;
  logic [W-1:0]     mcand;
  logic [W-1:0]     mplier;
  logic [W-1:0]     acc_next;

  assign acc_next = acc + (mplier[0] ? mcand : '0);
  // done flags the final step; product already includes that step's addend.
  assign done     = running && (count == CNT_W'(W - 1));
  assign product  = acc_next;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, matching the hardware it describes.
  always_ff @(posedge clock) begin
    if (reset) begin
      running <= 1'b0;
      count   <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
    end else if (start) begin
      running <= 1'b1;
      count   <= '0;
      acc     <= '0;
      mcand   <= a;
      mplier  <= b;
    end else if (running) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle control and execute stage: accepts one instruction, reads the
// register file, computes the result and issues a single write strobe.
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  read_reg_addr_1,
  output logic [ADDR_W-1:0]  read_reg_addr_2,
  input  logic [DATA_W-1:0]  read_data_1,
  input  logic [DATA_W-1:0]  read_data_2,
  output logic               regWrite,
  output logic [ADDR_W-1:0]  write_reg_addr,
  output logic [DATA_W-1:0]  write_data,
  output logic               busy,
  output logic               done,
  output logic               illegal
);

  state_t             state;
  state_t             state_next;
  logic [INSTR_W-1:0] instr_q;
  opcode_t            op;
  logic [ADDR_W-1:0]  rd;
  logic [FIELD_W-1:0] imm4;
  logic [IMM8_W-1:0]  imm8;
  logic               accept;
  logic               op_legal;
  logic               alu_writes;
  logic               mul_start;
  logic               mul_done;
  logic [DATA_W-1:0]  alu_result;
  logic [DATA_W-1:0]  mul_product;

  assign op         = instr_q[OP_LSB +: FIELD_W];
  assign rd         = instr_q[RD_LSB +: ADDR_W];
  assign imm4       = instr_q[IMM4_LSB +: FIELD_W];
  assign imm8       = instr_q[IMM8_LSB +: IMM8_W];
  assign op_legal   = is_legal(op);
  assign alu_writes = op_legal && (op != OP_NOP) && (op != OP_MUL);
  assign accept     = instr_valid && instr_ready;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // NOTE: every always_comb output gets a default before the case, otherwise
  // an uncovered path infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (accept) state_next = S_DECODE;
      S_DECODE: state_next = S_EXEC;
      S_EXEC: begin
        if (op == OP_MUL)  state_next = S_MUL;
        else if (!op_legal) state_next = S_IDLE;
        else               state_next = S_WB;
      end
      S_MUL:    if (mul_done) state_next = S_WB;
      S_WB:     state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Gating with reset keeps a mid-instruction reset from leaking a write,
  // done or illegal pulse during the reset cycle itself.
  always_comb begin
    instr_ready = 1'b0;
    busy        = 1'b0;
    regWrite    = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    mul_start   = 1'b0;
    if (!reset) begin
      instr_ready = (state == S_IDLE);
      busy        = (state != S_IDLE);
      regWrite    = (state == S_WB) && (op != OP_NOP);
      done        = (state == S_WB);
      illegal     = (state == S_EXEC) && !op_legal;
      mul_start   = (state == S_EXEC) && (op == OP_MUL);
    end
  end

  always_comb begin
    alu_result = '0;
    case (op)
      OP_LOAD: alu_result = DATA_W'(imm8);
      OP_ADD:  alu_result = read_data_1 + read_data_2;
      OP_SUB:  alu_result = read_data_1 - read_data_2;
      OP_ADDI: alu_result = read_data_1 + {{(DATA_W-FIELD_W){imm4[FIELD_W-1]}}, imm4};
      default: alu_result = '0;
    endcase
  end

  // Read addresses load at accept so they are stable for DECODE and EXEC;
  // the write port only changes when a new result is produced.
  always_ff @(posedge clock) begin
    if (reset) begin
      instr_q         <= '0;
      read_reg_addr_1 <= '0;
      read_reg_addr_2 <= '0;
      write_reg_addr  <= '0;
      write_data      <= '0;
    end else begin
      if (accept) begin
        instr_q         <= instr;
        read_reg_addr_1 <= instr[RS1_LSB +: ADDR_W];
        read_reg_addr_2 <= instr[RS2_LSB +: ADDR_W];
      end
      if (state == S_EXEC && alu_writes) begin
        write_reg_addr <= rd;
        write_data     <= alu_result;
      end
      if (state == S_MUL && mul_done) begin
        write_reg_addr <= rd;
        write_data     <= mul_product;
      end
    end
  end

  cpu_mul_iter #(.W(DATA_W)) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start),
    .a       (read_data_1),
    .b       (read_data_2),
    .done    (mul_done),
    .product (mul_product)
  );

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit with a behavioural register file
// attached to its read and write ports.
module tb_cpu_control_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [3:0]  read_reg_addr_1;
  logic [3:0]  read_reg_addr_2;
  logic [15:0] read_data_1;
  logic [15:0] read_data_2;
  logic        regWrite;
  logic [3:0]  write_reg_addr;
  logic [15:0] write_data;
  logic        busy;
  logic        done;
  logic        illegal;

  logic [15:0] rf [16] = '{default: 16'h0000};
  logic        poke_en = 1'b0;
  logic [3:0]  poke_addr = '0;
  logic [15:0] poke_data = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  cpu_control_unit dut (
    .clock           (clock),
    .reset           (reset),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .read_reg_addr_1 (read_reg_addr_1),
    .read_reg_addr_2 (read_reg_addr_2),
    .read_data_1     (read_data_1),
    .read_data_2     (read_data_2),
    .regWrite        (regWrite),
    .write_reg_addr  (write_reg_addr),
    .write_data      (write_data),
    .busy            (busy),
    .done            (done),
    .illegal         (illegal)
  );

  assign read_data_1 = rf[read_reg_addr_1];
  assign read_data_2 = rf[read_reg_addr_2];

  always @(posedge clock) begin
    if (regWrite) rf[write_reg_addr] <= write_data;
    if (poke_en)  rf[poke_addr] <= poke_data;
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic poke(input logic [3:0] addr, input logic [15:0] data);
    @(negedge clock);
    poke_en = 1'b1; poke_addr = addr; poke_data = data;
    @(posedge clock);
    #1 poke_en = 1'b0;
  endtask

  // Issues one instruction and records, by cycle number after the handshake
  // edge, when the write, done, illegal and ready were first seen.
  task automatic run_instr(input logic [15:0] ins, input bit hold,
                           output int wr_cyc, output logic [3:0] wr_addr,
                           output logic [15:0] wr_data, output int n_wr,
                           output int done_cyc, output int ill_cyc,
                           output int rdy_cyc, output bit busy_ok);
    wr_cyc = -1; wr_addr = '0; wr_data = '0; n_wr = 0;
    done_cyc = -1; ill_cyc = -1; rdy_cyc = -1; busy_ok = 1'b1;
    @(negedge clock);
    instr_valid = 1'b1; instr = ins;
    @(posedge clock);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (k == 1) begin
        instr_valid = hold;
        instr       = 16'h1ACC;
      end
      if (regWrite) begin
        if (wr_cyc < 0) begin
          wr_cyc = k; wr_addr = write_reg_addr; wr_data = write_data;
        end
        n_wr++;
      end
      if (done && done_cyc < 0) done_cyc = k;
      if (illegal && ill_cyc < 0) ill_cyc = k;
      if (instr_ready) begin
        rdy_cyc     = k;
        instr_valid = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic expect_run(input string tag, input logic [15:0] ins, input bit hold,
                            input int exp_wr_cyc, input logic [3:0] exp_addr,
                            input logic [15:0] exp_data, input int exp_done_cyc,
                            input int exp_ill_cyc, input int exp_rdy_cyc);
    int wr_cyc, n_wr, done_cyc, ill_cyc, rdy_cyc;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    bit busy_ok;
    run_instr(ins, hold, wr_cyc, wr_addr, wr_data, n_wr, done_cyc, ill_cyc, rdy_cyc, busy_ok);
    check($sformatf("%s.wr_cyc", tag), wr_cyc, exp_wr_cyc);
    check($sformatf("%s.n_wr", tag), n_wr, (exp_wr_cyc < 0) ? 0 : 1);
    if (exp_wr_cyc >= 0) begin
      check($sformatf("%s.wr_addr", tag), wr_addr, exp_addr);
      check($sformatf("%s.wr_data", tag), wr_data, exp_data);
    end
    check($sformatf("%s.done_cyc", tag), done_cyc, exp_done_cyc);
    check($sformatf("%s.ill_cyc", tag), ill_cyc, exp_ill_cyc);
    check($sformatf("%s.rdy_cyc", tag), rdy_cyc, exp_rdy_cyc);
    check($sformatf("%s.busy", tag), busy_ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_ready;
    bit saw_write;
    reset = 1'b1; instr_valid = 1'b0; instr = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst.ready", instr_ready, 0);
    check("rst.busy", busy, 0);
    check("rst.regWrite", regWrite, 0);
    check("rst.done", done, 0);
    check("rst.illegal", illegal, 0);
    check("rst.raddr1", read_reg_addr_1, 0);
    check("rst.raddr2", read_reg_addr_2, 0);
    check("rst.waddr", write_reg_addr, 0);
    check("rst.wdata", write_data, 0);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst.ready", instr_ready, 1);

    expect_run("load", 16'h135A, 1'b0, 3, 4'd3, 16'h005A, 3, -1, 4);
    check("load.rf3", rf[3], 16'h005A);

    poke(4'd1, 16'hFFFF);
    poke(4'd2, 16'h0002);
    expect_run("add", 16'h2412, 1'b0, 3, 4'd4, 16'h0001, 3, -1, 4);
    expect_run("sub", 16'h3521, 1'b1, 3, 4'd5, 16'h0003, 3, -1, 4);
    check("sub.raddr1", read_reg_addr_1, 4'd2);
    check("sub.raddr2", read_reg_addr_2, 4'd1);
    check("busy_valid.rf10", rf[10], 16'h0000);

    poke(4'd1, 16'h0010);
    expect_run("addi", 16'h461F, 1'b0, 3, 4'd6, 16'h000F, 3, -1, 4);

    // Dependent pair: ADDI r6 result feeds ADD r11,r6,r6.
    expect_run("dep", 16'h2B66, 1'b0, 3, 4'd11, 16'h001E, 3, -1, 4);

    poke(4'd1, 16'h0123);
    poke(4'd2, 16'h0100);
    expect_run("mul", 16'h5712, 1'b0, 19, 4'd7, 16'h2300, 19, -1, 20);
    check("mul.rf7", rf[7], 16'h2300);

    expect_run("illegal", 16'hA123, 1'b0, -1, 4'd0, 16'h0000, -1, 2, 3);
    expect_run("nop", 16'h0000, 1'b0, -1, 4'd0, 16'h0000, 3, -1, 4);
    check("hold.waddr", write_reg_addr, 4'd7);
    check("hold.wdata", write_data, 16'h2300);

    expect_run("clr", 16'h6300, 1'b0, 3, 4'd3, 16'h0000, 3, -1, 4);

    // Reset during the 8th MUL cycle (cycle 10) with valid held high.
    poke(4'd8, 16'hBEEF);
    saw_ready = 1'b0; saw_write = 1'b0;
    @(negedge clock);
    instr_valid = 1'b1; instr = 16'h5812;
    @(posedge clock);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (k == 1) instr = 16'h1ACC;
      if (instr_ready) saw_ready = 1'b1;
      if (regWrite) saw_write = 1'b1;
      if (k == 10) reset = 1'b1;
    end
    check("midrst.ready_while_busy", saw_ready, 0);
    check("midrst.regWrite_in_reset_cycle", regWrite, 0);
    @(negedge clock);
    check("midrst.ready", instr_ready, 0);
    check("midrst.busy", busy, 0);
    check("midrst.done", done, 0);
    check("midrst.illegal", illegal, 0);
    check("midrst.wdata", write_data, 0);
    check("midrst.waddr", write_reg_addr, 0);
    check("midrst.raddr1", read_reg_addr_1, 0);
    reset = 1'b0; instr_valid = 1'b0;
    @(negedge clock);
    check("midrst.ready_after", instr_ready, 1);
    check("midrst.no_write", saw_write || regWrite, 0);
    check("midrst.rf8", rf[8], 16'hBEEF);
    check("midrst.rf10", rf[10], 16'h0000);

    expect_run("recover", 16'h1977, 1'b0, 3, 4'd9, 16'h0077, 3, -1, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
